vid_pattern_gen: RTL and testbench

Source-side vid_io generator: produces the pixel/timing stream (data, hsync, vsync, VDE) that the colour/filter processing blocks consume. Generates 1080p60 raster timing (2200x1125 total) from free-running counters and fills the active region with a selectable test pattern. Used as a camera substitute for bring-up and to feed the filter pipeline with known, repeatable frames.

---
 rtl/vid_pattern_gen_if.sv | 26 ++
 rtl/vid_pattern_gen.sv | 145 ++++++++++++++
 tb/tb_vid_pattern_gen.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_pattern_gen_if.sv
// vid_pattern_gen_if
// Video output bundle of the pattern generator: pixel data, syncs, active-video
// flag, the raster position of the pixel being presented and a frame marker.
//   master : driven by the generator
//   slave  : consumed by downstream colour/filter blocks
interface vid_pattern_gen_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] o_vid_data;
  logic                  o_vid_hsync;
  logic                  o_vid_vsync;
  logic                  o_vid_VDE;
  logic [11:0]           o_hcount;
  logic [10:0]           o_vcount;
  logic                  o_frame_start;

  modport master (
    output o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
           o_hcount, o_vcount, o_frame_start
  );

  modport slave (
    input  o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
           o_hcount, o_vcount, o_frame_start
  );
endinterface

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen
// Free-running raster generator (1080p60 by default) with selectable test
// pattern in the active region. Every output is registered one cycle after the
// raster position it describes.
// Ports:
//   clk      pixel clock
//   rst      synchronous reset, active-high
//   en       generator enable; low parks the raster at (0,0) and blanks outputs
//   sw       pattern select: 0 bars, 1 ramp, 2 checkerboard, 3 solid
//   i_solid  colour used by the solid pattern (sampled every pixel)
//   vid      output bundle (master modport)
module vid_pattern_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            sw,
  input  logic [DATA_WIDTH-1:0] i_solid,
  vid_pattern_gen_if.master     vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0]           h_cnt;
  logic [10:0]           v_cnt;
  logic [1:0]            pat_q;
  logic [11:0]           bar_cnt;   // pixels left in current bar, down-counter
  logic [2:0]            bar_idx;

  logic                  at_origin;
  logic [1:0]            pat_cur;
  logic                  de;
  logic                  hs;
  logic                  vs;
  logic [23:0]           bar_rgb;
  logic [7:0]            ramp;
  logic [DATA_WIDTH-1:0] pix;

  always_comb begin
    at_origin = (h_cnt == 12'd0) && (v_cnt == 11'd0);
    // The pixel at (0,0) already uses the pattern being latched on that cycle,
    // so a whole frame is always drawn with one pattern.
    pat_cur   = at_origin ? sw : pat_q;
    de        = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    ramp      = h_cnt[10:3];

    // Packing is R[23:16], B[15:8], G[7:0].
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFF00FF;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h0000FF;
      3'd4: bar_rgb = 24'hFFFF00;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h00FF00;
      default: bar_rgb = 24'h000000;
    endcase

    pix = '0;
    case (pat_cur)
      2'd0: pix = DATA_WIDTH'(bar_rgb);
      2'd1: pix = DATA_WIDTH'({ramp, ramp, ramp});
      2'd2: pix = (h_cnt[5] ^ v_cnt[5]) ? '0 : '1;
      default: pix = i_solid;
    endcase
    if (!de) pix = '0;
  end

  // Raster counters; the bar counter restarts with every line so bars never
  // drift even though there is no divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= BAR_LAST;
      bar_idx <= '0;
      pat_q   <= '0;
    end else if (!en) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_cnt <= BAR_LAST;
      bar_idx <= '0;
    end else begin
      if (at_origin) pat_q <= sw;
      if (h_cnt == H_LAST) begin
        h_cnt   <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        bar_cnt <= BAR_LAST;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + 12'd1;
        if (bar_cnt == 12'd0) begin
          bar_cnt <= BAR_LAST;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt - 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      vid.o_vid_data    <= '0;
      vid.o_vid_hsync   <= 1'b0;
      vid.o_vid_vsync   <= 1'b0;
      vid.o_vid_VDE     <= 1'b0;
      vid.o_hcount      <= '0;
      vid.o_vcount      <= '0;
      vid.o_frame_start <= 1'b0;
    end else begin
      vid.o_vid_data    <= pix;
      vid.o_vid_hsync   <= hs;
      vid.o_vid_vsync   <= vs;
      vid.o_vid_VDE     <= de;
      vid.o_hcount      <= h_cnt;
      vid.o_vcount      <= v_cnt;
      vid.o_frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
module tb_vid_pattern_gen;
  // Reduced raster so several whole frames fit in a short run.
  localparam int DW  = 24;
  localparam int HA  = 64, HF = 4, HS = 6, HB = 6;
  localparam int VA  = 40, VF = 2, VS = 3, VB = 3;
  localparam int HT  = HA + HF + HS + HB;   // 80
  localparam int VT  = VA + VF + VS + VB;   // 48
  localparam int FRAME = HT * VT;           // 3840
  localparam int BW  = HA / 8;              // 8

  typedef struct packed {
    logic [23:0] data;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] hc;
    logic [10:0] vc;
    logic        fs;
  } vo_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    sw;
  logic [DW-1:0] i_solid;

  vid_pattern_gen_if #(.DATA_WIDTH(DW)) vid ();

  vid_pattern_gen #(
    .DATA_WIDTH(DW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sw(sw),
    .i_solid(i_solid),
    .vid(vid)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  int   sb_fail_prints = 0;
  vo_t  sbq[$];
  vo_t  last_obs;
  int   mh = 0, mv = 0;
  logic [1:0] mpat = 2'd0;

  function automatic logic [23:0] bar_colour(input int idx);
    logic [23:0] tbl [8];
    tbl[0] = 24'hFFFFFF; tbl[1] = 24'hFF00FF; tbl[2] = 24'h00FFFF; tbl[3] = 24'h0000FF;
    tbl[4] = 24'hFFFF00; tbl[5] = 24'hFF0000; tbl[6] = 24'h00FF00; tbl[7] = 24'h000000;
    return tbl[idx];
  endfunction

  function automatic vo_t model_out(input int h, input int v, input logic [1:0] pat,
                                    input logic [23:0] solid);
    vo_t o;
    logic [7:0] r;
    o    = '0;
    o.de = (h < HA) && (v < VA);
    o.hs = (h >= HA + HF) && (h < HA + HF + HS);
    o.vs = (v >= VA + VF) && (v < VA + VF + VS);
    o.hc = 12'(h);
    o.vc = 11'(v);
    o.fs = (h == 0) && (v == 0);
    if (o.de) begin
      r = 8'((h >> 3) & 255);
      case (pat)
        2'd0: o.data = bar_colour(h / BW);
        2'd1: o.data = {r, r, r};
        2'd2: o.data = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
        default: o.data = solid;
      endcase
    end
    return o;
  endfunction

  function automatic vo_t sample();
    vo_t o;
    o.data = vid.o_vid_data;
    o.hs   = vid.o_vid_hsync;
    o.vs   = vid.o_vid_vsync;
    o.de   = vid.o_vid_VDE;
    o.hc   = vid.o_hcount;
    o.vc   = vid.o_vcount;
    o.fs   = vid.o_frame_start;
    return o;
  endfunction

  // One clock: predict from current inputs, push, clock, pop and compare.
  task automatic tick();
    vo_t e;
    vo_t got;
    logic [1:0] p;
    if (rst || !en) begin
      e  = '0;
      mh = 0;
      mv = 0;
      if (rst) mpat = 2'd0;
    end else begin
      p = (mh == 0 && mv == 0) ? sw : mpat;
      mpat = p;
      e = model_out(mh, mv, p, i_solid);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sample();
    last_obs = got;
    e = sbq.pop_front();
    checks++;
    if (got !== e) begin
      if (sb_fail_prints < 10)
        $display("FAIL scoreboard t=%0t got=%h expected=%h", $time, got, e);
      sb_fail_prints++;
    end else begin
      passed++;
    end
  endtask

  task automatic advance_to(input int h, input int v);
    int budget;
    budget = 2 * FRAME;
    while (!(mh == h && mv == v) && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (mh == h && mv == v) passed++;
    else $display("FAIL advance_to(%0d,%0d) timeout at (%0d,%0d)", h, v, mh, mv);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sw = 2'd0; i_solid = 24'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (last_obs !== '0) $display("FAIL reset_outputs got=%h required=0", last_obs);
      else passed++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (last_obs.fs !== 1'b1 || last_obs.hc !== 12'd0 || last_obs.de !== 1'b1)
      $display("FAIL reset_release fs=%b hc=%0d de=%b required fs=1 hc=0 de=1",
               last_obs.fs, last_obs.hc, last_obs.de);
    else passed++;
  endtask

  task automatic test_timing();
    int de_run = 0, de_runs = 0, bad_de = 0;
    int hs_run = 0, hs_runs = 0, bad_hs = 0;
    int last_de_rise = -1, bad_off = 0, last_hs_rise = -1, bad_per = 0;
    int vs_cnt = 0, de_cnt = 0, bad_blank_de = 0;
    int fs_t[$];
    logic prev_de = 1'b0, prev_hs = 1'b0;
    sw = 2'd0;
    advance_to(0, 0);
    for (int cyc = 0; cyc < 2 * FRAME; cyc++) begin
      tick();
      if (last_obs.fs) fs_t.push_back(cyc);
      if (last_obs.de && !prev_de) last_de_rise = cyc;
      if (last_obs.de) de_run++;
      else begin
        if (prev_de) begin de_runs++; if (de_run != HA) bad_de++; end
        de_run = 0;
      end
      if (last_obs.hs) begin
        if (!prev_hs) begin
          if (last_obs.vc < 11'(VA) && cyc - last_de_rise != HA + HF) bad_off++;
          if (last_hs_rise >= 0 && cyc - last_hs_rise != HT) bad_per++;
          last_hs_rise = cyc;
        end
        hs_run++;
      end else begin
        if (prev_hs) begin hs_runs++; if (hs_run != HS) bad_hs++; end
        hs_run = 0;
      end
      if (cyc < FRAME && last_obs.vs) vs_cnt++;
      if (cyc < FRAME && last_obs.de) de_cnt++;
      if (last_obs.de && last_obs.vc >= 11'(VA)) bad_blank_de++;
      prev_de = last_obs.de;
      prev_hs = last_obs.hs;
    end
    checks++; if (bad_de != 0 || de_runs != 2 * VA)
      $display("FAIL vde_runs bad=%0d runs=%0d required 0/%0d", bad_de, de_runs, 2 * VA); else passed++;
    checks++; if (bad_hs != 0 || hs_runs != 2 * VT)
      $display("FAIL hsync_width bad=%0d runs=%0d required 0/%0d", bad_hs, hs_runs, 2 * VT); else passed++;
    checks++; if (bad_off != 0) $display("FAIL hsync_offset bad=%0d required 0", bad_off); else passed++;
    checks++; if (bad_per != 0) $display("FAIL line_period bad=%0d required 0", bad_per); else passed++;
    checks++; if (vs_cnt != VS * HT) $display("FAIL vsync_len got=%0d required=%0d", vs_cnt, VS * HT); else passed++;
    checks++; if (de_cnt != HA * VA) $display("FAIL vde_count got=%0d required=%0d", de_cnt, HA * VA); else passed++;
    checks++; if (bad_blank_de != 0) $display("FAIL vde_blank_lines got=%0d required 0", bad_blank_de); else passed++;
    checks++;
    if (fs_t.size() != 2 || fs_t[1] - fs_t[0] != FRAME)
      $display("FAIL frame_period pulses=%0d required 2 with period %0d", fs_t.size(), FRAME);
    else passed++;
  endtask

  task automatic test_colour_bars();
    logic [23:0] ld [HT];
    sw = 2'd0;
    advance_to(0, 0);
    for (int i = 0; i < HT; i++) begin
      tick();
      ld[i] = last_obs.data;
    end
    checks++; if (ld[0] !== 24'hFFFFFF) $display("FAIL bar_px0 got=%h required=FFFFFF", ld[0]); else passed++;
    checks++; if (ld[BW-1] !== 24'hFFFFFF) $display("FAIL bar_px_last0 got=%h required=FFFFFF", ld[BW-1]); else passed++;
    checks++; if (ld[BW] !== 24'hFF00FF) $display("FAIL bar_px_yellow got=%h required=FF00FF", ld[BW]); else passed++;
    checks++; if (ld[2*BW] !== 24'h00FFFF) $display("FAIL bar_px_cyan got=%h required=00FFFF", ld[2*BW]); else passed++;
    checks++; if (ld[5*BW] !== 24'hFF0000) $display("FAIL bar_px_red got=%h required=FF0000", ld[5*BW]); else passed++;
    checks++; if (ld[HA-1] !== 24'h000000) $display("FAIL bar_px_end got=%h required=000000", ld[HA-1]); else passed++;
    checks++; if (ld[HA] !== 24'h000000) $display("FAIL bar_blank got=%h required=000000", ld[HA]); else passed++;
  endtask

  task automatic test_patterns();
    logic [23:0] ld [HT];
    logic [23:0] a = 24'h5A5A5A, b = 24'h5A5A5A, c = 24'h5A5A5A;
    int bad_solid = 0, bad_blank = 0, act = 0;
    sw = 2'd1;
    advance_to(0, 0);
    for (int i = 0; i < HT; i++) begin tick(); ld[i] = last_obs.data; end
    checks++; if (ld[HA-1] !== 24'h070707) $display("FAIL ramp_end got=%h required=070707", ld[HA-1]); else passed++;
    checks++; if (ld[8] !== 24'h010101) $display("FAIL ramp_px8 got=%h required=010101", ld[8]); else passed++;

    sw = 2'd2;
    advance_to(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (last_obs.hc == 12'd0  && last_obs.vc == 11'd0)  a = last_obs.data;
      if (last_obs.hc == 12'd32 && last_obs.vc == 11'd0)  b = last_obs.data;
      if (last_obs.hc == 12'd32 && last_obs.vc == 11'd32) c = last_obs.data;
    end
    checks++; if (a !== 24'hFFFFFF) $display("FAIL checker_0_0 got=%h required=FFFFFF", a); else passed++;
    checks++; if (b !== 24'h000000) $display("FAIL checker_32_0 got=%h required=000000", b); else passed++;
    checks++; if (c !== 24'hFFFFFF) $display("FAIL checker_32_32 got=%h required=FFFFFF", c); else passed++;

    sw = 2'd3; i_solid = 24'h123456;
    advance_to(0, 0);
    for (int i = 0; i < FRAME; i++) begin
      tick();
      if (last_obs.de) begin act++; if (last_obs.data !== 24'h123456) bad_solid++; end
      else if (last_obs.data !== 24'h0) bad_blank++;
    end
    checks++; if (bad_solid != 0 || act != HA * VA)
      $display("FAIL solid_active bad=%0d active=%0d required 0/%0d", bad_solid, act, HA * VA); else passed++;
    checks++; if (bad_blank != 0) $display("FAIL solid_blank bad=%0d required 0", bad_blank); else passed++;
  endtask

  task automatic test_midframe_sw();
    logic [23:0] a = 24'h5A5A5A, b = 24'h5A5A5A, c = 24'h5A5A5A;
    sw = 2'd0;
    advance_to(0, 0);
    advance_to(0, 20);
    sw = 2'd2;
    while (!(mh == 40 && mv == 0)) begin
      tick();
      if (last_obs.hc == 12'd8 && last_obs.vc == 11'd30) a = last_obs.data;
      if (last_obs.hc == 12'd8 && last_obs.vc == 11'd0)  b = last_obs.data;
      if (last_obs.hc == 12'd32 && last_obs.vc == 11'd0) c = last_obs.data;
    end
    checks++; if (a !== 24'hFF00FF) $display("FAIL midframe_keeps_bars got=%h required=FF00FF", a); else passed++;
    checks++; if (b !== 24'hFFFFFF) $display("FAIL nextframe_checker_8 got=%h required=FFFFFF", b); else passed++;
    checks++; if (c !== 24'h000000) $display("FAIL nextframe_checker_32 got=%h required=000000", c); else passed++;
  endtask

  task automatic test_en_drop();
    sw = 2'd0;
    advance_to(5, 10);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (last_obs !== '0) $display("FAIL en_low_outputs got=%h required=0", last_obs); else passed++;
    end
    en = 1'b1;
    tick();
    checks++;
    if (last_obs.fs !== 1'b1 || last_obs.hc !== 12'd0 || last_obs.vc !== 11'd0)
      $display("FAIL en_restart fs=%b hc=%0d vc=%0d required 1/0/0", last_obs.fs, last_obs.hc, last_obs.vc);
    else passed++;
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_rst_mid();
    sw = 2'd0;
    advance_to(20, 15);
    rst = 1'b1;
    sw = 2'd3; i_solid = 24'hABCDEF;
    tick();
    checks++;
    if (last_obs !== '0) $display("FAIL rst_mid_outputs got=%h required=0", last_obs); else passed++;
    rst = 1'b0;
    tick();
    checks++;
    if (last_obs.fs !== 1'b1 || last_obs.hc !== 12'd0 || last_obs.data !== 24'hABCDEF)
      $display("FAIL rst_restart fs=%b hc=%0d data=%h required 1/0/ABCDEF",
               last_obs.fs, last_obs.hc, last_obs.data);
    else passed++;
    for (int i = 0; i < 100; i++) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sw = 2'd0; i_solid = '0;
    @(negedge clk);
    test_reset();
    test_timing();
    test_colour_bars();
    test_patterns();
    test_midframe_sw();
    test_en_drop();
    test_rst_mid();
    checks++;
    if (sbq.size() != 0) $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end
endmodule
